// File: rtl/fxp_pkg.sv
// fxp_pkg: shared constants and record types for the fixed-point add scheduler.
//   FXP_I_BITS / FXP_F_BITS : default integer / fraction split (Q2.14).
//   FXP_W                   : default data width.
//   FXP_ID_W                : requester-id width able to hold up to 16 requesters.
//   fxp_req_t               : one issued operation {a, b, is_signed, id}.
//   fxp_res_t               : one delivered result {c, ovf, id}.
package fxp_pkg;

  localparam int FXP_I_BITS = 2;
  localparam int FXP_F_BITS = 14;
  localparam int FXP_W      = FXP_I_BITS + FXP_F_BITS;
  localparam int FXP_ID_W   = 4;

  typedef struct packed {
    logic [FXP_W-1:0]    a;
    logic [FXP_W-1:0]    b;
    logic                is_signed;
    logic [FXP_ID_W-1:0] id;
  } fxp_req_t;

  typedef struct packed {
    logic [FXP_W-1:0]    c;
    logic                ovf;
    logic [FXP_ID_W-1:0] id;
  } fxp_res_t;

endpackage

// File: rtl/fxp_sat_add.sv
// fxp_sat_add: combinational saturating fixed-point adder.
//   a, b      in  W  operands (same Q format)
//   is_signed in  1  1 = two's-complement add, 0 = unsigned add
//   c         out W  sum, clamped to the representable range
//   ovf       out 1  the true sum did not fit and c was clamped
module fxp_sat_add
  import fxp_pkg::*;
#(
  parameter int I_BITS = FXP_I_BITS,
  parameter int F_BITS = FXP_F_BITS
) (
  input  logic [I_BITS+F_BITS-1:0] a,
  input  logic [I_BITS+F_BITS-1:0] b,
  input  logic                     is_signed,
  output logic [I_BITS+F_BITS-1:0] c,
  output logic                     ovf
);

  localparam int W = I_BITS + F_BITS;

  logic [W:0] sum_s;
  logic [W:0] sum_u;

  always_comb begin
    sum_s = {a[W-1], a} + {b[W-1], b};
    sum_u = {1'b0, a} + {1'b0, b};
    c     = sum_u[W-1:0];
    ovf   = 1'b0;
    if (is_signed) begin
      c = sum_s[W-1:0];
      // Sign of the W+1-bit sum disagrees with the W-bit sign: out of range.
      // sum_s[W] is the true sign and picks the clamp direction.
      if (sum_s[W] != sum_s[W-1]) begin
        ovf = 1'b1;
        c   = sum_s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
    end else if (sum_u[W]) begin
      ovf = 1'b1;
      c   = '1;
    end
  end

endmodule

// File: rtl/fxp_add_sched.sv
// fxp_add_sched: round-robin sharing of one saturating adder among N_REQ
// requesters, through a two-register pipeline (S1 operands, S2 result).
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a/req_b           packed operands, requester i at [i*W +: W]
//   req_signed            per-requester add mode
//   res_valid/res_ready   result handshake, res_* driven straight from S2
//   res_c/res_ovf/res_id  saturated sum, clamp flag, issuing requester
//   cnt_clr               synchronous clear of ovf_cnt (wins over increment)
//   ovf_cnt               saturating count of delivered overflowed results
module fxp_add_sched
  import fxp_pkg::*;
#(
  parameter int  N_REQ  = 4,
  parameter int  I_BITS = FXP_I_BITS,
  parameter int  F_BITS = FXP_F_BITS,
  parameter int  CNT_W  = 16,
  localparam int W      = I_BITS + F_BITS,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_signed,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_c,
  output logic               res_ovf,
  output logic [ID_W-1:0]    res_id,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   ovf_cnt
);

  logic            s1_v_q,   s1_v_d;
  logic [W-1:0]    s1_a_q,   s1_a_d;
  logic [W-1:0]    s1_b_q,   s1_b_d;
  logic            s1_sgn_q, s1_sgn_d;
  logic [ID_W-1:0] s1_id_q,  s1_id_d;
  logic            s2_v_q,   s2_v_d;
  logic [W-1:0]    s2_c_q,   s2_c_d;
  logic            s2_ovf_q, s2_ovf_d;
  logic [ID_W-1:0] s2_id_q,  s2_id_d;
  logic [ID_W-1:0] ptr_q,    ptr_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            s2_load;
  logic            s1_can_take;
  logic            accept;
  logic [W-1:0]    add_c;
  logic            add_ovf;
  logic [W-1:0]    a_arr [N_REQ];
  logic [W-1:0]    b_arr [N_REQ];

  assign s2_load     = s1_v_q && (!s2_v_q || res_ready);
  assign s1_can_take = !s1_v_q || s2_load;
  assign accept      = s1_can_take && grant_found;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign a_arr[gi]     = req_a[gi*W +: W];
      assign b_arr[gi]     = req_b[gi*W +: W];
      assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // First valid requester at or after ptr, wrapping past N_REQ-1 to 0.
  always_comb begin
    logic [ID_W:0] pos;
    grant_found = 1'b0;
    grant_idx   = '0;
    pos         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(N_REQ)) pos = pos - (ID_W+1)'(N_REQ);
      if (!grant_found && req_valid[pos[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = pos[ID_W-1:0];
      end
    end
  end

  fxp_sat_add #(.I_BITS(I_BITS), .F_BITS(F_BITS)) u_add (
    .a         (s1_a_q),
    .b         (s1_b_q),
    .is_signed (s1_sgn_q),
    .c         (add_c),
    .ovf       (add_ovf)
  );

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_sgn_d  = s1_sgn_q;
    s1_id_d   = s1_id_q;
    s2_v_d    = s2_v_q;
    s2_c_d    = s2_c_q;
    s2_ovf_d  = s2_ovf_q;
    s2_id_d   = s2_id_q;
    ptr_d     = ptr_q;
    ovf_cnt_d = ovf_cnt_q;

    if (s1_can_take) s1_v_d = accept;
    if (accept) begin
      s1_a_d   = a_arr[grant_idx];
      s1_b_d   = b_arr[grant_idx];
      s1_sgn_d = req_signed[grant_idx];
      s1_id_d  = grant_idx;
      ptr_d    = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);
    end

    // S2 payload only changes on a load, so a stalled result stays put.
    if (s2_load) begin
      s2_v_d   = 1'b1;
      s2_c_d   = add_c;
      s2_ovf_d = add_ovf;
      s2_id_d  = s1_id_q;
    end else if (res_ready) begin
      s2_v_d = 1'b0;
    end

    if (cnt_clr) begin
      ovf_cnt_d = '0;
    end else if (s2_v_q && res_ready && s2_ovf_q && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_sgn_q  <= 1'b0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_c_q    <= '0;
      s2_ovf_q  <= 1'b0;
      s2_id_q   <= '0;
      ptr_q     <= '0;
      ovf_cnt_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_sgn_q  <= s1_sgn_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_c_q    <= s2_c_d;
      s2_ovf_q  <= s2_ovf_d;
      s2_id_q   <= s2_id_d;
      ptr_q     <= ptr_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign res_valid = s2_v_q;
  assign res_c     = s2_c_q;
  assign res_ovf   = s2_ovf_q;
  assign res_id    = s2_id_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule
